// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: per-stage payload layouts, control field and widths.
// A control field of all zeros is a NOP (bubble) in every stage.
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

    typedef struct packed {
        logic [1:0] wb;
        logic [2:0] mem;
        logic [2:0] ex;
    } stage_ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_data_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [16:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } idex_data_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] rs2_val;
        logic [4:0]  rd;
    } exmem_data_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
    } memwb_data_t;

    localparam stage_ctrl_t NOP_CTRL = '0;

    localparam int IFID_CTRL_W  = $bits(stage_ctrl_t);
    localparam int IDEX_CTRL_W  = $bits(stage_ctrl_t);
    localparam int EXMEM_CTRL_W = $bits(stage_ctrl_t);
    localparam int MEMWB_CTRL_W = $bits(stage_ctrl_t);

    localparam int IFID_DATA_W  = $bits(ifid_data_t);
    localparam int IDEX_DATA_W  = $bits(idex_data_t);
    localparam int EXMEM_DATA_W = $bits(exmem_data_t);
    localparam int MEMWB_DATA_W = $bits(memwb_data_t);

endpackage

// File: rtl/pipe_entry_reg.sv
// One loadable storage entry (control + payload) of a pipeline stage register.
module pipe_entry_reg #(
    parameter int W = 136
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush, optional
// two-entry skid buffer (registered ready) and a saturating stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occ_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    input  logic              stall_cnt_clr_i
);

    localparam int ENTRY_W = CTRL_W + DATA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    occ_state_e         state_q, state_d;
    logic               rdy_q;
    logic               in_ready, out_valid, in_fire, out_fire;
    logic               load_main, load_skid, main_from_skid;
    logic [ENTRY_W-1:0] in_beat, main_d, main_q, skid_q;
    logic [CNT_W-1:0]   stall_cnt_q;

    assign in_beat   = {in_ctrl_i, in_data_i};
    assign out_valid = (state_q != OCC_EMPTY);
    assign out_fire  = out_valid & out_ready_i;
    assign in_fire   = in_valid_i & in_ready & ~flush_i;

    // rdy_q is low in reset and rises on the first edge after release; with
    // a skid buffer it alone is the ready, so out_ready_i never reaches in_ready_o.
    assign in_ready = (SKID != 0) ? rdy_q : (rdy_q & (~out_valid | out_ready_i));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= OCC_EMPTY;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != OCC_TWO);
        end
    end

    // Main entry always holds the older beat; the skid entry only fills when
    // a beat arrives while the main entry is stalled.
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush_i) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        load_main = 1'b1;
                        state_d   = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (in_fire && out_fire) begin
                        load_main = 1'b1;
                    end else if (in_fire && (SKID != 0)) begin
                        load_skid = 1'b1;
                        state_d   = OCC_TWO;
                    end else if (out_fire) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (out_fire) begin
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = OCC_ONE;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : in_beat;

    pipe_entry_reg #(.W(ENTRY_W)) u_main (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load  (load_main),
        .d     (main_d),
        .q     (main_q)
    );

    if (SKID != 0) begin : g_skid
        pipe_entry_reg #(.W(ENTRY_W)) u_skid (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .load  (load_skid),
            .d     (in_beat),
            .q     (skid_q)
        );
    end else begin : g_noskid
        assign skid_q = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (stall_cnt_clr_i) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_ready_i && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign in_ready_o  = in_ready;
    assign out_valid_o = out_valid;
    assign out_ctrl_o  = out_valid ? main_q[ENTRY_W-1 -: CTRL_W] : '0;
    assign out_data_o  = main_q[DATA_W-1:0];
    assign occ_o       = state_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- One generic stage register carrying a control field and a data field, with:
  - valid/ready handshake (stall back-pressure)
  - synchronous flush
  - optional two-entry skid buffer, so ready does not ripple combinationally through the pipeline
  - saturating stall-cycle counter for performance analysis
- Instantiated between every pair of pipeline stages in the core.

Parameters:
- CTRL_W, 8, width of control field (WB/M/EX bits); forced to zero in bubbles.
- DATA_W, 128, width of payload (PC, operands, immediate, register addresses, packed).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready_o; 0 = single entry with combinational in_ready_o.
- CNT_W, 16, width of stall counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- flush_i  in  1  synchronous flush: kill held and incoming beats.
- in_valid_i  in  1  upstream beat valid.
- in_ready_o  out  1  stage can accept a beat.
- in_ctrl_i  in  CTRL_W  upstream control field.
- in_data_i  in  DATA_W  upstream payload.
- out_valid_o  out  1  downstream beat valid.
- out_ready_i  in  1  downstream accepts.
- out_ctrl_o  out  CTRL_W  control field; all zero when out_valid_o=0.
- out_data_o  out  DATA_W  payload; value held when out_valid_o=0.
- occ_o  out  2  entries held (0..2; max 1 when SKID=0).
- stall_cnt_o  out  CNT_W  cycles with out_valid_o=1 and out_ready_i=0, saturating.
- stall_cnt_clr_i  in  1  synchronous clear of stall_cnt_o.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous, active-high.
- Reset values: all registers 0 (out_valid_o=0, out_ctrl_o=0, out_data_o=0, occ_o=0, stall_cnt_o=0).
  - in_ready_o=0 during reset.
  - in_ready_o=1 on the first clock after deassertion.
- Handshake:
  - Input transfer: in_valid_i & in_ready_o at a rising edge.
  - Output transfer: out_valid_o & out_ready_i at a rising edge.
  - While out_valid_o=1 and out_ready_i=0, out_ctrl_o and out_data_o stay stable.
  - in_valid_i may drop without a transfer; the stage never depends on it staying high.
- Latency: 1 cycle in-to-out when empty. Throughput 1 beat/cycle with out_ready_i held high.
- SKID=1, states by occupancy:
  - EMPTY: accept -> ONE.
  - ONE: accept & no output transfer -> TWO (beat stored in skid entry). Accept & output transfer -> ONE (main reloaded). Output transfer only -> EMPTY.
  - TWO: output transfer -> ONE (skid moves to main). Else stay.
  - in_ready_o is registered: 1 iff next state != TWO. No combinational path from out_ready_i to in_ready_o.
  - Order preserved: main entry is always the older beat.
- SKID=0:
  - Single entry; in_ready_o = ~out_valid_o | out_ready_i (combinational).
  - Accept & output transfer in the same cycle reloads the entry.
- Flush:
  - Highest priority over all transfers.
  - At the edge with flush_i=1: occupancy -> 0, out_valid_o -> 0, out_ctrl_o -> 0. Any beat offered that cycle is discarded, even if in_ready_o=1.
  - Data fields retain their value.
  - A downstream transfer in the flush cycle still counts as delivered.
- Bubble rule: out_ctrl_o is masked to zero whenever out_valid_o=0. This matches the existing stages, where a zero control field is a NOP.
- Stall counter:
  - +1 each cycle with out_valid_o & ~out_ready_i.
  - Saturates at 2^CNT_W-1.
  - stall_cnt_clr_i clears it; clear wins over increment.
  - Flush does not clear it.
- Reset mid-operation: all entries dropped immediately (asynchronous). No beat is emitted after reset deassertion until a new input transfer.

Decomposition:
- Shared package pipe_pkg holds:
  - per-stage CTRL_W/DATA_W constants (IFID, IDEX, EXMEM, MEMWB)
  - packed struct typedefs for each stage payload
  - a NOP control constant, all zero
- Natural sub-module: pipe_entry_reg, one enable-loadable CTRL_W+DATA_W register with async reset, instantiated for the main and skid entries.
- Counter stays inline.

Test Plan:
- Streaming: SKID=1, out_ready_i=1, send ctrl 0x01..0x05 back-to-back -> out_ctrl_o 0x01..0x05 on consecutive cycles, 1 cycle later; in_ready_o stays 1; stall_cnt_o=0.
- Back-pressure:
  - Stimulus: SKID=1, out_ready_i=0, send A=0x11, B=0x22, C=0x33.
  - Required response: occ_o=2 after B, in_ready_o=0 the next cycle, C held upstream.
  - Then raise out_ready_i -> A, B, C emitted in order, none lost or duplicated.
  - stall_cnt_o counts the low cycles exactly.
- Flush:
  - Stimulus: occ_o=2, pulse flush_i with in_valid_i=1, ctrl 0x44.
  - Required response: next cycle out_valid_o=0, out_ctrl_o=0x00, occ_o=0; 0x44 never appears.
- SKID=0 combinational ready: full stage with out_ready_i toggling -> in_ready_o follows out_ready_i in the same cycle; data stable while stalled.
- Counter:
  - Stimulus: CNT_W=4, stall 20 cycles.
  - Required response: stall_cnt_o saturates at 15.
  - stall_cnt_clr_i together with a stall cycle -> 0.
- Async reset: assert rst_i between clock edges with occ_o=2 -> outputs 0 immediately; in_ready_o=1 on the first edge after release; no stale beat emitted.
